// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: turns make/break/E0-prefixed byte sequences into
// one-cycle KEY_PRESSED command pulses and a per-key held mask.
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES = 1_250_000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [7:0]  ps2_data,
   input  logic        ps2_data_en,
   output logic [4:0]  KEY_PRESSED,
   output logic        key_valid,
   output logic [16:0] key_held
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0] KEY_IDLE = 5'd31;

   typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
   logic [16:0]   held_nxt;
   logic [4:0]    key_nxt;
   logic          is_ctrl, ext, brk, final_byte, map_hit;
   logic [4:0]    map_code;

   assign ext = (state == GOT_E0) || (state == GOT_E0F0);
   assign brk = (state == GOT_F0) || (state == GOT_E0F0);

   always_comb begin
      case (ps2_data)
         8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFF, 8'h00: is_ctrl = 1'b1;
         default:                                 is_ctrl = 1'b0;
      endcase
   end

   // Arrow keys and numpad share base codes; only the E0 prefix tells them apart.
   always_comb begin
      map_hit  = 1'b1;
      map_code = 5'd0;
      if (ext) begin
         case (ps2_data)
            8'h75:   map_code = 5'd0;
            8'h72:   map_code = 5'd1;
            8'h6B:   map_code = 5'd2;
            8'h74:   map_code = 5'd3;
            default: map_hit  = 1'b0;
         endcase
      end else begin
         case (ps2_data)
            8'h1D:   map_code = 5'd4;
            8'h1B:   map_code = 5'd5;
            8'h1C:   map_code = 5'd6;
            8'h23:   map_code = 5'd7;
            8'h43:   map_code = 5'd8;
            8'h42:   map_code = 5'd9;
            8'h3B:   map_code = 5'd10;
            8'h4B:   map_code = 5'd11;
            8'h75:   map_code = 5'd12;
            8'h73:   map_code = 5'd13;
            8'h6B:   map_code = 5'd14;
            8'h74:   map_code = 5'd15;
            8'h29:   map_code = 5'd16;
            default: map_hit  = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_nxt   = state;
      tmo_cnt_nxt = tmo_cnt;
      held_nxt    = key_held;
      key_nxt     = KEY_IDLE;
      final_byte  = 1'b0;
      if (ps2_data_en) begin
         tmo_cnt_nxt = '0;
         if (is_ctrl) begin
            state_nxt = IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (ps2_data == 8'hF0)      state_nxt  = GOT_F0;
                  else if (ps2_data == 8'hE0) state_nxt  = GOT_E0;
                  else                        final_byte = 1'b1;
               end
               GOT_E0: begin
                  if (ps2_data == 8'hF0)      state_nxt  = GOT_E0F0;
                  else if (ps2_data != 8'hE0) final_byte = 1'b1;
               end
               GOT_F0, GOT_E0F0: begin
                  if (ps2_data == 8'hE0) state_nxt  = GOT_E0;
                  else                   final_byte = 1'b1;
               end
               default: state_nxt = IDLE;
            endcase
         end
         if (final_byte) begin
            state_nxt = IDLE;
            // A make for a key already held is typematic repeat: no pulse.
            if (map_hit) begin
               if (brk) begin
                  held_nxt[map_code] = 1'b0;
               end else if (!key_held[map_code]) begin
                  held_nxt[map_code] = 1'b1;
                  key_nxt            = map_code;
               end
            end
         end
      end else if (state != IDLE) begin
         if (tmo_cnt == TMO_LAST) begin
            state_nxt   = IDLE;
            tmo_cnt_nxt = '0;
         end else begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state       <= IDLE;
         tmo_cnt     <= '0;
         KEY_PRESSED <= KEY_IDLE;
         key_valid   <= 1'b0;
         key_held    <= '0;
      end else begin
         state       <= state_nxt;
         tmo_cnt     <= tmo_cnt_nxt;
         KEY_PRESSED <= key_nxt;
         key_valid   <= (key_nxt != KEY_IDLE);
         key_held    <= held_nxt;
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized bench for ps2_key_decoder: a prefix-flag model predicts every
// cycle's outputs; directed sequences pin the model with literal values.
module tb_ps2_key_decoder;

   localparam int TMO = 20;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  ps2_data = 8'h00;
   logic        ps2_data_en = 1'b0;
   logic [4:0]  KEY_PRESSED;
   logic        key_valid;
   logic [16:0] key_held;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .ps2_data(ps2_data),
      .ps2_data_en(ps2_data_en), .KEY_PRESSED(KEY_PRESSED),
      .key_valid(key_valid), .key_held(key_held)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   logic [7:0] arrows [4]  = '{8'h75, 8'h72, 8'h6B, 8'h74};
   logic [7:0] plain  [13] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h43, 8'h42, 8'h3B,
                               8'h4B, 8'h75, 8'h73, 8'h6B, 8'h74, 8'h29};
   logic [7:0] ctrls  [6]  = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFF, 8'h00};

   function automatic int code_of(bit e, logic [7:0] b);
      if (e) begin
         for (int i = 0; i < 4; i++) if (arrows[i] == b) return i;
      end else begin
         for (int i = 0; i < 13; i++) if (plain[i] == b) return i + 4;
      end
      return -1;
   endfunction

   function automatic bit is_ctrl(logic [7:0] b);
      for (int i = 0; i < 6; i++) if (ctrls[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   // Model: a pending prefix is just two flags plus an idle-cycle count.
   bit        m_ext, m_brk;
   int        m_idle, m_key, m_c;
   bit [16:0] m_held;

   always @(posedge CLOCK_50) begin
      m_key = 31;
      if (reset) begin
         m_ext = 0; m_brk = 0; m_idle = 0; m_held = '0;
      end else if (ps2_data_en) begin
         m_idle = 0;
         if (is_ctrl(ps2_data)) begin
            m_ext = 0; m_brk = 0;
         end else if (ps2_data == 8'hE0) begin
            m_ext = 1; m_brk = 0;
         end else if (ps2_data == 8'hF0 && !m_brk) begin
            m_brk = 1;
         end else begin
            m_c = code_of(m_ext, ps2_data);
            if (m_c >= 0) begin
               if (m_brk) m_held[m_c] = 1'b0;
               else if (!m_held[m_c]) begin
                  m_held[m_c] = 1'b1;
                  m_key = m_c;
               end
            end
            m_ext = 0; m_brk = 0;
         end
      end else if (m_ext || m_brk) begin
         m_idle++;
         if (m_idle == TMO) begin
            m_ext = 0; m_brk = 0; m_idle = 0;
         end
      end
   end

   always @(negedge CLOCK_50) begin
      if (chk_on) begin
         n_cmp++;
         if (KEY_PRESSED != 5'(m_key) || key_valid != (m_key != 31) || key_held != m_held) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t: got key=%0d valid=%0b held=%h, expected key=%0d valid=%0b held=%h",
                     $time, KEY_PRESSED, key_valid, key_held, m_key, (m_key != 31), m_held);
         end
      end
   end

   task automatic lit(string nm, int got, int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic send(logic [7:0] b);
      @(negedge CLOCK_50); ps2_data = b; ps2_data_en = 1'b1;
      @(negedge CLOCK_50); ps2_data_en = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) begin @(negedge CLOCK_50); ps2_data_en = 1'b0; end
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50); reset = 1'b1; ps2_data_en = 1'b0;
      @(negedge CLOCK_50); reset = 1'b0;
   endtask

   function automatic logic [7:0] pick();
      int r;
      r = $urandom_range(0, 99);
      if (r < 60)      return plain[$urandom_range(0, 12)];
      else if (r < 75) return 8'hE0;
      else if (r < 88) return 8'hF0;
      else if (r < 94) return ctrls[$urandom_range(0, 5)];
      else             return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      @(posedge CLOCK_50); #1 chk_on = 1'b1;
      @(negedge CLOCK_50);
      lit("reset_key", int'(KEY_PRESSED), 31);
      lit("reset_valid", int'(key_valid), 0);
      lit("reset_held", int'(key_held), 0);
      reset = 1'b0;

      send(8'hE0); send(8'h75);
      lit("e0_75_key", int'(KEY_PRESSED), 0);
      lit("e0_75_valid", int'(key_valid), 1);
      lit("e0_75_held0", int'(key_held[0]), 1);
      idle(1);
      lit("e0_75_pulse_end", int'(KEY_PRESSED), 31);

      do_reset();
      send(8'h75);
      lit("numpad8_key", int'(KEY_PRESSED), 12);
      send(8'hE0); send(8'hF0); send(8'h75);
      lit("arrow_break_key", int'(KEY_PRESSED), 31);
      lit("arrow_break_held12", int'(key_held[12]), 1);
      send(8'hF0); send(8'h75);
      lit("numpad_break_held12", int'(key_held[12]), 0);
      lit("numpad_break_key", int'(KEY_PRESSED), 31);

      send(8'h1D);
      lit("w_first", int'(KEY_PRESSED), 4);
      send(8'h1D);
      lit("w_repeat1", int'(KEY_PRESSED), 31);
      send(8'h1D);
      lit("w_repeat2", int'(KEY_PRESSED), 31);
      send(8'hF0); send(8'h1D); send(8'h1D);
      lit("w_second", int'(KEY_PRESSED), 4);

      do_reset();
      send(8'hE0); idle(TMO - 1); send(8'h75);
      lit("timeout_fired", int'(KEY_PRESSED), 12);
      do_reset();
      send(8'hE0); idle(TMO - 2); send(8'h75);
      lit("timeout_strobe_wins", int'(KEY_PRESSED), 0);

      do_reset();
      send(8'h1D); send(8'hF0);
      @(negedge CLOCK_50); reset = 1'b1; ps2_data = 8'h29; ps2_data_en = 1'b1;
      @(negedge CLOCK_50);
      lit("in_reset_key", int'(KEY_PRESSED), 31);
      lit("in_reset_held", int'(key_held), 0);
      reset = 1'b0; ps2_data_en = 1'b0;
      send(8'h29);
      lit("space_after_reset", int'(KEY_PRESSED), 16);

      do_reset();
      send(8'hE0); send(8'hFA); send(8'h6B);
      lit("fa_clears_prefix", int'(KEY_PRESSED), 14);
      send(8'hAA);
      lit("aa_no_pulse", int'(KEY_PRESSED), 31);
      lit("aa_held", int'(key_held), 32'h4000);

      for (int i = 0; i < 4000; i++) begin
         @(negedge CLOCK_50);
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 99) < 45) begin
            ps2_data = pick(); ps2_data_en = 1'b1;
         end else begin
            ps2_data_en = 1'b0;
         end
         if ($urandom_range(0, 99) == 0) begin
            @(negedge CLOCK_50); reset = 1'b0;
            idle($urandom_range(TMO - 2, TMO + 1));
         end
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
